// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the seven-segment scan
//               controller: hex-to-segment table, blank patterns, scan states.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // All segments dark (active-low {g,f,e,d,c,b,a})
  localparam logic [6:0] SEG_OFF = 7'h7F;
  // All anodes off (active-low)
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Scan slot phase: BLANK gap first, then the digit is driven
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Active-low patterns indexed by nibble value; entry 0 is rightmost
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational nibble to active-low seven-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Straight table lookup; one entry per hex digit
  assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit common-anode
//               seven-segment display. Each digit slot starts with a blanking
//               gap, new values are double-buffered and applied only at the
//               frame boundary. Optional macro SEG7_LEADING_ZERO_BLANK_EN
//               turns off digits above the highest nonzero nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  input  logic [3:0]  digit_mask,
  output logic        pending,
  output logic        frame_start,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int            TW          = $clog2(DIGIT_TICKS);
  localparam logic [TW-1:0] c_TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] c_BLANK_LAST = TW'(BLANK_TICKS - 1);

  // Scan FSM state
  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [1:0]    r_digit;
  logic [1:0]    w_digit_nxt;
  logic          w_slot_end;
  logic          w_boundary;

  // Double-buffered display value
  logic [15:0]   r_active;
  logic [15:0]   r_pend_buf;
  logic          r_pending;

  // Output path
  logic [3:0]    w_nibble;
  logic [6:0]    w_dec_seg;
  logic [3:0]    w_lz_mask;
  logic          w_show;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_fs_nxt;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_fs;

  assign w_slot_end = (r_tick == c_TICK_LAST);
  // Last cycle of the last digit slot is the only point where active changes
  assign w_boundary = (r_digit == 2'd3) && w_slot_end;

  // Scan state register: slot phase, tick within slot, current digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BLANK;
      r_tick  <= '0;
      r_digit <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  // Next-state: BLANK for the first BLANK_TICKS of a slot, ON until slot end
  always_comb begin
    w_tick_nxt  = w_slot_end ? '0 : r_tick + TW'(1);
    w_digit_nxt = w_slot_end ? r_digit + 2'd1 : r_digit;
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   if (r_tick == c_BLANK_LAST) w_state_nxt = ON;
      ON:      if (w_slot_end)             w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  // Value buffering: loads park in the pending buffer until the boundary;
  // a load landing on the boundary itself goes straight to active
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active   <= '0;
      r_pend_buf <= '0;
      r_pending  <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_active  <= value;
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_active  <= r_pend_buf;
        r_pending <= 1'b0;
      end
    end else if (load) begin
      r_pend_buf <= value;
      r_pending  <= 1'b1;
    end
  end

  // Select the nibble belonging to the digit currently being scanned
  always_comb begin
    w_nibble = r_active[3:0];
    case (r_digit)
      2'd0:    w_nibble = r_active[3:0];
      2'd1:    w_nibble = r_active[7:4];
      2'd2:    w_nibble = r_active[11:8];
      2'd3:    w_nibble = r_active[15:12];
      default: w_nibble = r_active[3:0];
    endcase
  end

  seg7_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is shown only if it or some more significant nibble is nonzero;
  // digit 0 always stays so that zero reads as a single "0"
  assign w_lz_mask = {|r_active[15:12], |r_active[15:8], |r_active[15:4], 1'b1};
`else
  assign w_lz_mask = 4'b1111;
`endif

  // Output decode from the current FSM position
  always_comb begin
    w_show    = (r_state == ON) && enable && digit_mask[r_digit] && w_lz_mask[r_digit];
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    if (w_show) begin
      w_an_nxt  = ~(4'b0001 << r_digit);
      w_seg_nxt = w_dec_seg;
    end
    w_fs_nxt  = (r_digit == 2'd0) && (r_tick == '0);
  end

  // Registered outputs: glitch-free drive of the shared seg bus and anodes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_fs  <= 1'b0;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_fs  <= w_fs_nxt;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_start = r_fs;
  assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl with DIGIT_TICKS=8,
//               BLANK_TICKS=2 (32-cycle frame). A frame-position model pushes
//               the expected registered outputs per cycle; they are popped and
//               compared after each clock edge, plus directed spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int FRAME = 4 * DT;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        enable;
  logic [3:0]  digit_mask;
  logic        pending;
  logic        frame_start;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .load        (load),
    .enable      (enable),
    .digit_mask  (digit_mask),
    .pending     (pending),
    .frame_start (frame_start),
    .seg         (seg),
    .an          (an)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: position within frame plus buffered values
  int          m_pos    = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_buf    = '0;
  logic        m_pend   = 1'b0;

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic ref_lz(input logic [15:0] a, input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b1;
    return (a >> (4 * d)) != 16'h0;
`else
    return (a == a) || (d >= 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict registered outputs from current inputs, clock, compare
  task automatic step();
    exp_t e;
    exp_t got;
    int   d;
    int   t;
    logic show;
    if (rst) begin
      e.an     = 4'hF;
      e.seg    = 7'h7F;
      e.fs     = 1'b0;
      e.pend   = 1'b0;
      m_pos    = 0;
      m_active = '0;
      m_buf    = '0;
      m_pend   = 1'b0;
    end else begin
      d     = m_pos / DT;
      t     = m_pos % DT;
      show  = (t >= BT) && enable && digit_mask[d] && ref_lz(m_active, d);
      e.an  = show ? ~(4'b0001 << d) : 4'hF;
      e.seg = show ? ref_dec(m_active[4*d +: 4]) : 7'h7F;
      e.fs  = (m_pos == 0);
      if (m_pos == FRAME - 1) begin
        if (load) begin
          m_active = value;
          m_pend   = 1'b0;
        end else if (m_pend) begin
          m_active = m_buf;
          m_pend   = 1'b0;
        end
      end else if (load) begin
        m_buf  = value;
        m_pend = 1'b1;
      end
      e.pend = m_pend;
      m_pos  = (m_pos + 1) % FRAME;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb_an",      16'(an),          16'(got.an));
    check("sb_seg",     16'(seg),         16'(got.seg));
    check("sb_fs",      16'(frame_start), 16'(got.fs));
    check("sb_pending", 16'(pending),     16'(got.pend));
  endtask

  // Step until the model is about to process frame position p
  task automatic run_until(input int p);
    while (m_pos != p) step();
  endtask

  int   fs_cnt;
  logic an_bad;

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    value      = 16'h0;
    enable     = 1'b1;
    digit_mask = 4'hF;

    // Reset state
    repeat (3) step();
    check("rst_an",   16'(an),  16'(4'hF));
    check("rst_seg",  16'(seg), 16'(7'h7F));
    rst = 1'b0;

    // 1: load 1234 at cycle 3, applied at the boundary, shown next frame
    step();
    check("t1_fs_after_release", 16'(frame_start), 16'(1'b1));
    run_until(3);
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    check("t1_pending_set", 16'(pending), 16'(1'b1));
    run_until(31);
    check("t1_pending_held", 16'(pending), 16'(1'b1));
    step();
    check("t1_pending_clr", 16'(pending), 16'(1'b0));
    run_until(3);
    check("t1_an_d0",  16'(an),  16'(4'b1110));
    check("t1_seg_d0", 16'(seg), 16'(7'b0011001));
    run_until(11);
    check("t1_an_d1",  16'(an),  16'(4'b1101));
    check("t1_seg_d1", 16'(seg), 16'(7'b0110000));
    run_until(19);
    check("t1_an_d2",  16'(an),  16'(4'b1011));
    check("t1_seg_d2", 16'(seg), 16'(7'b0100100));
    run_until(27);
    check("t1_an_d3",  16'(an),  16'(4'b0111));
    check("t1_seg_d3", 16'(seg), 16'(7'b1111001));

    // 2: two loads in one frame, last one wins
    run_until(5);
    value = 16'hAAAA; load = 1'b1;
    step();
    load = 1'b0;
    run_until(20);
    value = 16'hBEEF; load = 1'b1;
    step();
    load = 1'b0;
    run_until(0);
    check("t2_pending_clr", 16'(pending), 16'(1'b0));
    run_until(3);
    check("t2_seg_d0", 16'(seg), 16'(7'b0001110));
    run_until(11);
    check("t2_seg_d1", 16'(seg), 16'(7'b0000110));
    run_until(27);
    check("t2_seg_d3", 16'(seg), 16'(7'b0000011));

    // 3: load on the boundary cycle bypasses the pending buffer
    run_until(31);
    value = 16'h00F0; load = 1'b1;
    step();
    load = 1'b0;
    check("t3_no_pending", 16'(pending), 16'(1'b0));
    run_until(11);
    check("t3_an_d1",  16'(an),  16'(4'b1101));
    check("t3_seg_d1", 16'(seg), 16'(7'b0001110));

    // 4a: enable low for a full frame, frame_start still pulses once
    run_until(0);
    enable = 1'b0;
    fs_cnt = 0;
    an_bad = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an !== 4'hF) an_bad = 1'b1;
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("t4_an_off",   16'(an_bad), 16'(1'b0));
    check("t4_fs_count", 16'(fs_cnt), 16'(1));

    // 4b: digit mask 0101, digits 1 and 3 never lit
    enable     = 1'b1;
    digit_mask = 4'b0101;
    an_bad     = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an[1] !== 1'b1 || an[3] !== 1'b1) an_bad = 1'b1;
    end
    check("t4_mask", 16'(an_bad), 16'(1'b0));
    digit_mask = 4'hF;

    // 5: reset mid-slot of digit 2 with a load pending
    run_until(3);
    value = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    run_until(19);
    rst = 1'b1;
    step();
    check("t5_rst_an",      16'(an),      16'(4'hF));
    check("t5_rst_seg",     16'(seg),     16'(7'h7F));
    check("t5_rst_pending", 16'(pending), 16'(1'b0));
    rst = 1'b0;
    step();
    check("t5_fs", 16'(frame_start), 16'(1'b1));
    step();
    check("t5_fs_pulse_end", 16'(frame_start), 16'(1'b0));
    check("t5_blank_gap",    16'(an),          16'(4'hF));
    step();
    check("t5_d0_on_an",  16'(an),  16'(4'b1110));
    check("t5_d0_on_seg", 16'(seg), 16'(7'b1000000));

    // 6: leading-zero handling with active = 0000, then 0007
    run_until(27);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check("t6_zero_d3", 16'(an), 16'(4'hF));
`else
    check("t6_zero_d3", 16'(an), 16'(4'b0111));
`endif
    run_until(31);
    value = 16'h0007; load = 1'b1;
    step();
    load = 1'b0;
    run_until(3);
    check("t6_d0_an",  16'(an),  16'(4'b1110));
    check("t6_d0_seg", 16'(seg), 16'(7'b1111000));
    run_until(19);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check("t6_d2_an", 16'(an), 16'(4'hF));
`else
    check("t6_d2_an",  16'(an),  16'(4'b1011));
    check("t6_d2_seg", 16'(seg), 16'(7'b1000000));
`endif
    run_until(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Owns the shared seg bus and the four anode lines.
- Sequences one digit at a time, with a blanking gap between digits to prevent ghosting.
- Displays a 16-bit hex value supplied by upstream logic.
- New values are double-buffered and applied only at frame boundaries, so no torn frames appear.

Parameters:
DIGIT_TICKS, 100000, clk cycles per digit slot (BLANK + ON); must be > BLANK_TICKS
BLANK_TICKS, 1000, clk cycles at start of each slot with all anodes off; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
value  input  16  hex value to display; nibble [3:0] on rightmost digit (an[0])
load  input  1  single-cycle strobe: capture value into pending buffer
enable  input  1  0 forces all anodes off; scan timing keeps running
digit_mask  input  4  per-digit enable; bit d=0 keeps an[d] off
pending  output  1  high while a captured value awaits the next frame boundary
frame_start  output  1  one-cycle pulse on entry to digit 0 BLANK phase
seg  output  7  active-low segments {g,f,e,d,c,b,a}; 1111111 = all off
an  output  4  active-low anodes; 1111 = all off

Behaviour:
- Reset (synchronous, rst=1 at posedge) sets:
  - state=BLANK, digit index d=0, tick=0
  - active=16'h0000, pending buffer=0, pending=0, frame_start=0
  - an=4'b1111, seg=7'b1111111
- Tick counter width: $clog2(DIGIT_TICKS). Counts 0..DIGIT_TICKS-1 per slot and wraps to 0.
- FSM states: BLANK, ON.
  - BLANK: held while tick < BLANK_TICKS. Outputs an=1111, seg=1111111.
  - ON: held for the remaining DIGIT_TICKS-BLANK_TICKS cycles.
  - When tick=DIGIT_TICKS-1: d <= (d+1) mod 4, state <= BLANK.
- Frame: 4 slots, d = 0,1,2,3. Frame length = 4*DIGIT_TICKS cycles.
  - Frame boundary = last cycle of slot d=3.
- Outputs seg, an, frame_start are registered, so they lag the FSM by 1 cycle.
  - In ON for digit d with enable=1 and digit_mask[d]=1: an = ~(4'b0001<<d), seg = decode(active[4d+3:4d]).
  - Otherwise: an=1111, seg=1111111.
- Decode (hex, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Load handling:
  - load=1 in a non-boundary cycle: pending buffer <= value, pending <= 1.
  - Repeated loads before the boundary overwrite the buffer (last wins).
  - At the frame boundary with pending=1: active <= pending buffer, pending <= 0.
  - load=1 in the boundary cycle itself: active <= value directly (bypass), pending <= 0. This supersedes any older pending value.
- frame_start asserts for exactly 1 cycle, once per frame, coinciding with the first BLANK cycle of d=0.
  - Also asserts on the first cycle after reset release.
- enable and digit_mask are sampled every cycle with no latching. Changes mid-slot take effect on the next registered output.
- Reset mid-frame: output registers go to the reset state on the next cycle and scanning restarts at d=0. Any pending value is lost.

Optional Feature:
Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits more significant than the highest nonzero nibble of active are forced off (an bit=1).
  - Digit 0 is always shown, so active=0 displays a single "0".
  - Applied together with digit_mask (logical AND).
- Undefined: all four digits are shown, subject to enable/digit_mask only.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table
  - the constants SEG_OFF=7'h7F and AN_OFF=4'hF
  - the scan-state typedef {BLANK, ON}
- One sub-module, seg7_hex_decoder: combinational nibble -> 7-bit active-low pattern, instantiated once on the selected nibble.

Test Plan:
Bench parameters: DIGIT_TICKS=8, BLANK_TICKS=2 (frame = 32 cycles).
1. Reset, then load value=16'h1234 in cycle 3 -> pending=1 until the boundary at cycle 31. Second frame shows:
   - an=1110, seg=0011001 ("4")
   - an=1101, seg=0110000 ("3")
   - an=1011, seg=0100100 ("2")
   - an=0111, seg=1111001 ("1")
   Each digit is on for 6 cycles, separated by 2-cycle all-off gaps.
2. Load 16'hAAAA then 16'hBEEF in the same frame -> next frame shows BEEF only; pending clears exactly at the boundary.
3. Load 16'h00F0 asserted exactly on the boundary cycle -> applied in the very next frame, pending never rises.
4. enable=0 for a full frame -> an=1111 throughout, frame_start still pulses every 32 cycles; digit_mask=4'b0101 -> only an[0] and an[2] ever go low.
5. rst=1 mid-slot of digit 2 -> next cycle an=1111, seg=1111111, pending=0. First cycle after release has frame_start=1, and digit 0 ON starts 2 cycles later.
6. With SEG7_LEADING_ZERO_BLANK_EN, active=16'h0007 -> only an[0] is lit with seg=1111000. active=16'h0000 -> only digit 0 is lit with "0". Without the macro, all four digits are lit.
